// File: rtl/mac_array_unit_pkg.sv
// Shared types and sizing helpers for the mac_array_unit MAC engine.
// Address widths and the read count are derived here so every file sizes its ports the same way.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_e;

    localparam int DRAIN_CYCLES = 3;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int total_reads(input int m, input int k, input int n, input int lanes);
        return m * (n / lanes) * k;
    endfunction

endpackage

// File: rtl/mac_array_unit_lane.sv
// One multiply-accumulate lane: operand extension, product register, tag pipeline, accumulator.
// o_acc_next is the value the accumulator takes on the next edge, so the top can register it as C data.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_first,
    input  logic             i_signed,
    input  logic [DW-1:0]    i_a,
    input  logic [DW-1:0]    i_b,
    output logic [ACC_W-1:0] o_acc_next
);

    logic [2*DW-1:0]  w_a_x;
    logic [2*DW-1:0]  w_b_x;
    logic [2*DW-1:0]  w_prod;
    logic [ACC_W-1:0] w_prod_ext;

    logic             r_v1;
    logic             r_f1;
    logic             r_v2;
    logic             r_f2;
    logic [ACC_W-1:0] r_prod;
    logic [ACC_W-1:0] r_acc;

    // Extend operands to 2*DW; the low 2*DW product bits are then exact in both modes.
    always_comb begin
        w_a_x = {(2*DW){i_signed & i_a[DW-1]}};
        w_a_x[DW-1:0] = i_a;
        w_b_x = {(2*DW){i_signed & i_b[DW-1]}};
        w_b_x[DW-1:0] = i_b;
        w_prod = w_a_x * w_b_x;
        w_prod_ext = {ACC_W{i_signed & w_prod[2*DW-1]}};
        w_prod_ext[2*DW-1:0] = w_prod;
    end

    // A first-of-dot-product tag replaces the running sum instead of adding to it.
    always_comb begin
        if (r_f2) begin
            o_acc_next = r_prod;
        end else begin
            o_acc_next = r_acc + r_prod;
        end
    end

    // Tag pipeline, product register and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_f1   <= 1'b0;
            r_v2   <= 1'b0;
            r_f2   <= 1'b0;
            r_prod <= {ACC_W{1'b0}};
            r_acc  <= {ACC_W{1'b0}};
        end else begin
            r_v1 <= i_valid;
            r_f1 <= i_first;
            r_v2 <= r_v1;
            r_f2 <= r_f1;
            if (r_v1) begin
                r_prod <= w_prod_ext;
            end
            if (r_v2) begin
                r_acc <= o_acc_next;
            end
        end
    end

endmodule

// File: rtl/mac_array_unit.sv
// LANES-wide matrix multiply engine: C = A x B with A (M x K) and B (K x N) in external registered memories.
// Holds the control FSM, the m/g/k counters, address generation and the registered C write port.
module mac_array_unit
    import mac_pkg::*;
#(
    parameter int param_M            = 4,
    parameter int param_K            = 4,
    parameter int param_N            = 4,
    parameter int LANES              = 2,
    parameter int DATA_WIDTH_INITIAL = 8,
    parameter int ACC_WIDTH          = 2*DATA_WIDTH_INITIAL + $clog2(param_K)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      mac_start,
    input  logic                                      signed_mode,
    output logic                                      a_b_re,
    output logic [addr_w(param_M*param_K)-1:0]        a_addr_out,
    output logic [addr_w(param_K*param_N/LANES)-1:0]  b_addr_out,
    input  logic [DATA_WIDTH_INITIAL-1:0]             a_data_in,
    input  logic [LANES*DATA_WIDTH_INITIAL-1:0]       b_data_in,
    output logic                                      c_we,
    output logic [addr_w(param_M*param_N/LANES)-1:0]  c_addr_out,
    output logic [LANES*ACC_WIDTH-1:0]                c_data_out,
    output logic                                      busy,
    output logic                                      mac_done
);

    localparam int DW   = DATA_WIDTH_INITIAL;
    localparam int G    = param_N / LANES;
    localparam int AW_A = addr_w(param_M*param_K);
    localparam int AW_B = addr_w(param_K*G);
    localparam int AW_C = addr_w(param_M*G);
    localparam int MW   = addr_w(param_M);
    localparam int GW   = addr_w(G);
    localparam int KW   = addr_w(param_K);
    localparam int CW   = LANES*ACC_WIDTH;

    localparam logic [MW-1:0] M_LAST     = MW'(param_M - 1);
    localparam logic [GW-1:0] G_LAST     = GW'(G - 1);
    localparam logic [KW-1:0] K_LAST     = KW'(param_K - 1);
    localparam logic [1:0]    DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    mac_state_e      r_state;
    mac_state_e      w_state_nxt;
    logic [MW-1:0]   r_m;
    logic [MW-1:0]   w_m_nxt;
    logic [GW-1:0]   r_g;
    logic [GW-1:0]   w_g_nxt;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_nxt;
    logic [1:0]      r_drain;
    logic [1:0]      w_drain_nxt;
    logic            w_rd_nxt;
    logic            w_last_read;

    logic            r_a_b_re;
    logic [AW_A-1:0] r_a_addr;
    logic [AW_B-1:0] r_b_addr;
    logic            r_rd_first;
    logic            r_rd_last;
    logic [AW_C-1:0] r_rd_caddr;
    logic            r_signed;
    logic            r_busy;
    logic            r_mac_done;

    logic            r_last1;
    logic            r_last2;
    logic [AW_C-1:0] r_caddr1;
    logic [AW_C-1:0] r_caddr2;
    logic            r_c_we;
    logic [AW_C-1:0] r_c_addr;
    logic [CW-1:0]   r_c_data;
    logic [CW-1:0]   w_acc_next;

    // The counters always name the read presented on the ports this cycle.
    assign w_last_read = (r_m == M_LAST) && (r_g == G_LAST) && (r_k == K_LAST);

    // Next-state, counter advance (k inner, g middle, m outer) and read issue.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_g_nxt     = r_g;
        w_k_nxt     = r_k;
        w_drain_nxt = r_drain;
        w_rd_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mac_start) begin
                    w_state_nxt = ST_RUN;
                    w_m_nxt     = {MW{1'b0}};
                    w_g_nxt     = {GW{1'b0}};
                    w_k_nxt     = {KW{1'b0}};
                    w_rd_nxt    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last_read) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = 2'd0;
                end else begin
                    w_rd_nxt = 1'b1;
                    if (r_k != K_LAST) begin
                        w_k_nxt = r_k + {{(KW-1){1'b0}}, 1'b1};
                    end else if (r_g != G_LAST) begin
                        w_k_nxt = {KW{1'b0}};
                        w_g_nxt = r_g + {{(GW-1){1'b0}}, 1'b1};
                    end else begin
                        w_k_nxt = {KW{1'b0}};
                        w_g_nxt = {GW{1'b0}};
                        w_m_nxt = r_m + {{(MW-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drain == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_drain_nxt = r_drain + 2'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state, read port and per-read tags; addresses hold while no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_m        <= {MW{1'b0}};
            r_g        <= {GW{1'b0}};
            r_k        <= {KW{1'b0}};
            r_drain    <= 2'd0;
            r_a_b_re   <= 1'b0;
            r_a_addr   <= {AW_A{1'b0}};
            r_b_addr   <= {AW_B{1'b0}};
            r_rd_first <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_caddr <= {AW_C{1'b0}};
            r_signed   <= 1'b0;
            r_busy     <= 1'b0;
            r_mac_done <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_m      <= w_m_nxt;
            r_g      <= w_g_nxt;
            r_k      <= w_k_nxt;
            r_drain  <= w_drain_nxt;
            r_a_b_re <= w_rd_nxt;
            if (w_rd_nxt) begin
                r_a_addr   <= AW_A'(int'(w_m_nxt) * param_K + int'(w_k_nxt));
                r_b_addr   <= AW_B'(int'(w_k_nxt) * G + int'(w_g_nxt));
                r_rd_caddr <= AW_C'(int'(w_m_nxt) * G + int'(w_g_nxt));
                r_rd_first <= (w_k_nxt == {KW{1'b0}});
                r_rd_last  <= (w_k_nxt == K_LAST);
            end
            if ((r_state == ST_IDLE) && mac_start) begin
                r_signed <= signed_mode;
            end
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_mac_done <= (w_state_nxt == ST_DONE);
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (r_a_b_re),
            .i_first    (r_rd_first),
            .i_signed   (r_signed),
            .i_a        (a_data_in),
            .i_b        (b_data_in[j*DW +: DW]),
            .o_acc_next (w_acc_next[j*ACC_WIDTH +: ACC_WIDTH])
        );
    end

    // Last-of-dot-product tag and C address ride alongside the lane pipeline to the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last1  <= 1'b0;
            r_last2  <= 1'b0;
            r_caddr1 <= {AW_C{1'b0}};
            r_caddr2 <= {AW_C{1'b0}};
            r_c_we   <= 1'b0;
            r_c_addr <= {AW_C{1'b0}};
            r_c_data <= {CW{1'b0}};
        end else begin
            r_last1  <= r_a_b_re & r_rd_last;
            r_caddr1 <= r_rd_caddr;
            r_last2  <= r_last1;
            r_caddr2 <= r_caddr1;
            r_c_we   <= r_last2;
            if (r_last2) begin
                r_c_addr <= r_caddr2;
                r_c_data <= w_acc_next;
            end
        end
    end

    assign a_b_re     = r_a_b_re;
    assign a_addr_out = r_a_addr;
    assign b_addr_out = r_b_addr;
    assign c_we       = r_c_we;
    assign c_addr_out = r_c_addr;
    assign c_data_out = r_c_data;
    assign busy       = r_busy;
    assign mac_done   = r_mac_done;

endmodule

// File: tb/tb_mac_array_unit.sv
// Scoreboard bench for mac_array_unit: expected C words are queued at stimulus time and
// popped by per-DUT monitors whenever c_we is seen.
module tb_mac_array_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    // ---------------- DUT 1: defaults (M=K=N=4, LANES=2) ----------------
    logic        rst = 1'b1;
    logic        mac_start = 1'b0;
    logic        signed_mode = 1'b0;
    logic        a_b_re;
    logic [3:0]  a_addr;
    logic [2:0]  b_addr;
    logic [7:0]  a_data = 8'd0;
    logic [15:0] b_data = 16'd0;
    logic        c_we;
    logic [2:0]  c_addr;
    logic [35:0] c_data;
    logic        busy;
    logic        mac_done;

    logic [7:0]  a_mem [16];
    logic [7:0]  b_flat [16];
    logic [15:0] b_mem [8];

    mac_array_unit u_dut1 (
        .clk(clk), .rst(rst), .mac_start(mac_start), .signed_mode(signed_mode),
        .a_b_re(a_b_re), .a_addr_out(a_addr), .b_addr_out(b_addr),
        .a_data_in(a_data), .b_data_in(b_data),
        .c_we(c_we), .c_addr_out(c_addr), .c_data_out(c_data),
        .busy(busy), .mac_done(mac_done)
    );

    always @(posedge clk) begin
        if (a_b_re) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
        end
    end

    // ---------------- DUT 2: LANES=4, M=2, K=1, N=4 ----------------
    logic        mac_start2 = 1'b0;
    logic        a_b_re2;
    logic [0:0]  a_addr2;
    logic [0:0]  b_addr2;
    logic [7:0]  a_data2 = 8'd0;
    logic [31:0] b_data2 = 32'd0;
    logic        c_we2;
    logic [0:0]  c_addr2;
    logic [63:0] c_data2;
    logic        busy2;
    logic        mac_done2;

    logic [7:0]  a2_mem [2];
    logic [31:0] b2_mem [1];

    mac_array_unit #(
        .param_M(2), .param_K(1), .param_N(4), .LANES(4), .DATA_WIDTH_INITIAL(8)
    ) u_dut2 (
        .clk(clk), .rst(rst), .mac_start(mac_start2), .signed_mode(1'b0),
        .a_b_re(a_b_re2), .a_addr_out(a_addr2), .b_addr_out(b_addr2),
        .a_data_in(a_data2), .b_data_in(b_data2),
        .c_we(c_we2), .c_addr_out(c_addr2), .c_data_out(c_data2),
        .busy(busy2), .mac_done(mac_done2)
    );

    always @(posedge clk) begin
        if (a_b_re2) begin
            a_data2 <= a2_mem[a_addr2];
            b_data2 <= b2_mem[b_addr2];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int          w1_cnt = 0;
    logic [35:0] w1_first;
    logic [35:0] w1_last;

    always @(negedge clk) begin
        if (c_we === 1'b1) begin
            if (q1.size() == 0) begin
                check("c1_unexpected_we", 64'd1, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("c1_addr", {61'd0, c_addr}, e1.addr);
                check("c1_data", {28'd0, c_data}, e1.data);
            end
            if (w1_cnt == 0) w1_first = c_data;
            w1_last = c_data;
            w1_cnt++;
        end
    end

    always @(negedge clk) begin
        if (c_we2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("c2_unexpected_we", 64'd1, 64'd0);
            end else begin
                e2 = q2.pop_front();
                check("c2_addr", {63'd0, c_addr2}, e2.addr);
                check("c2_data", c_data2, e2.data);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic load1(input int mode);
        for (int i = 0; i < 16; i++) begin
            a_mem[i]  = (mode == 0) ? 8'(i) : 8'hFF;
            b_flat[i] = (mode == 0) ? 8'(i) : 8'h02;
        end
        for (int w = 0; w < 8; w++) b_mem[w] = {b_flat[2*w+1], b_flat[2*w]};
    endtask

    // Plain matrix product, pushed as one expected C word per (row, column group).
    task automatic push_model1(input bit sm);
        exp_t e;
        int   s;
        int   av;
        int   bv;
        for (int m = 0; m < 4; m++) begin
            for (int g = 0; g < 2; g++) begin
                e.addr = 4'(m*2 + g);
                e.data = 64'd0;
                for (int j = 0; j < 2; j++) begin
                    s = 0;
                    for (int k = 0; k < 4; k++) begin
                        av = sm ? int'($signed(a_mem[m*4+k]))       : int'(a_mem[m*4+k]);
                        bv = sm ? int'($signed(b_flat[k*4+g*2+j])) : int'(b_flat[k*4+g*2+j]);
                        s += av * bv;
                    end
                    e.data[j*18 +: 18] = 18'(s);
                end
                q1.push_back(e);
            end
        end
    endtask

    task automatic run1(input int rst_at, output int re_cnt, output int done_cyc, output int busy_fall);
        re_cnt = 0; done_cyc = -1; busy_fall = -1;
        @(negedge clk); mac_start = 1'b1;
        @(posedge clk); #1 mac_start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (a_b_re) re_cnt++;
            if (mac_done) done_cyc = n;
            if (rst_at == n) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_outputs_zero",
                      {14'd0, a_b_re, a_addr, b_addr, c_we, c_addr, c_data, busy, mac_done}, 64'd0);
                rst = 1'b0;
                break;
            end
            if (done_cyc >= 0 && !busy) begin
                busy_fall = n;
                break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int re, dn, bf, rd2, dn2, bad;
    int we_cyc [2];
    int we_n;

    initial begin
        load1(0);
        a2_mem[0] = 8'd3;
        a2_mem[1] = 8'd5;
        b2_mem[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              {14'd0, a_b_re, a_addr, b_addr, c_we, c_addr, c_data, busy, mac_done}, 64'd0);

        // Scenario 1: unsigned index pattern
        w1_cnt = 0;
        push_model1(1'b0);
        signed_mode = 1'b0;
        run1(0, re, dn, bf);
        check("s1_re_cycles", 64'(re), 64'd32);
        check("s1_done_cycle", 64'(dn), 64'd36);
        check("s1_busy_fall", 64'(bf), 64'd37);
        check("s1_we_count", 64'(w1_cnt), 64'd8);
        check("s1_first_word", {28'd0, w1_first}, {28'd0, 18'd62, 18'd56});
        check("s1_c33", {46'd0, w1_last[35:18]}, 64'd506);
        check("s1_queue_empty", 64'(q1.size()), 64'd0);

        // Scenario 2: all -1 x 2, signed then unsigned
        load1(1);
        w1_cnt = 0;
        push_model1(1'b1);
        signed_mode = 1'b1;
        run1(0, re, dn, bf);
        check("s2_signed_first", {28'd0, w1_first}, {28'd0, 18'h3FFF8, 18'h3FFF8});
        check("s2_signed_last", {28'd0, w1_last}, {28'd0, 18'h3FFF8, 18'h3FFF8});
        w1_cnt = 0;
        push_model1(1'b0);
        signed_mode = 1'b0;
        run1(0, re, dn, bf);
        check("s2_unsigned_last", {28'd0, w1_last}, {28'd0, 18'h007F8, 18'h007F8});
        check("s2_queue_empty", 64'(q1.size()), 64'd0);

        // Scenario 3: reset 10 cycles into a run, then a clean rerun
        load1(0);
        w1_cnt = 0;
        push_model1(1'b0);
        run1(10, re, dn, bf);
        check("s3_writes_before_rst", 64'(w1_cnt), 64'd1);
        check("s3_queue_left", 64'(q1.size()), 64'd7);
        q1.delete();
        bad = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (c_we || mac_done || a_b_re || busy) bad++;
        end
        check("s3_quiet_after_rst", 64'(bad), 64'd0);
        w1_cnt = 0;
        push_model1(1'b0);
        run1(0, re, dn, bf);
        check("s3_rerun_done", 64'(dn), 64'd36);
        check("s3_rerun_first", {28'd0, w1_first}, {28'd0, 18'd62, 18'd56});
        check("s3_rerun_c33", {46'd0, w1_last[35:18]}, 64'd506);

        // Scenario 4: mac_start held high across two runs
        w1_cnt = 0;
        push_model1(1'b0);
        push_model1(1'b0);
        dn = -1; dn2 = -1; bf = -1; rd2 = -1; re = 0;
        @(negedge clk); mac_start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (a_b_re) re++;
            if (mac_done) begin
                if (dn < 0) dn = n;
                else if (dn2 < 0) dn2 = n;
            end
            if (dn >= 0 && bf < 0 && !busy) bf = n;
            if (bf >= 0 && rd2 < 0 && a_b_re) rd2 = n;
            if (dn2 >= 0) break;
        end
        mac_start = 1'b0;
        repeat (3) @(negedge clk);
        check("s4_done1", 64'(dn), 64'd36);
        check("s4_busy_fall", 64'(bf), 64'd37);
        check("s4_run2_first_read", 64'(rd2), 64'd38);
        check("s4_done2", 64'(dn2), 64'd73);
        check("s4_re_total", 64'(re), 64'd64);
        check("s4_we_count", 64'(w1_cnt), 64'd16);
        check("s4_queue_empty", 64'(q1.size()), 64'd0);

        // Scenario 5: LANES=4, K=1 -> one write per read
        q2.push_back('{addr: 4'd0, data: {16'd12, 16'd9, 16'd6, 16'd3}});
        q2.push_back('{addr: 4'd1, data: {16'd20, 16'd15, 16'd10, 16'd5}});
        re = 0; dn = -1; we_n = 0; we_cyc[0] = -1; we_cyc[1] = -1;
        @(negedge clk); mac_start2 = 1'b1;
        @(posedge clk); #1 mac_start2 = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (a_b_re2) re++;
            if (c_we2 && we_n < 2) begin
                we_cyc[we_n] = n;
                we_n++;
            end
            if (mac_done2) begin
                dn = n;
                break;
            end
        end
        check("s5_re_cycles", 64'(re), 64'd2);
        check("s5_we1_cycle", 64'(we_cyc[0]), 64'd4);
        check("s5_we2_cycle", 64'(we_cyc[1]), 64'd5);
        check("s5_done_cycle", 64'(dn), 64'd6);
        check("s5_queue_empty", 64'(q2.size()), 64'd0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_array_unit.md
Name: mac_array_unit

Overview:
- Parametrised successor to the single-lane matrix MAC engine. Computes C = A x B, with A stored M x K row-major and B stored K x N row-major.
- Uses LANES parallel multiply-accumulate lanes. Each lane computes one column of a LANES-wide column group.
- Reads operands from external registered memories: A is one element per read, B is a LANES-wide word per read. Writes LANES results per C write.
- Adds a signed/unsigned mode, a widened accumulator and a busy flag.

Parameters:
- param_M, 4, rows of A and C
- param_K, 4, inner dimension
- param_N, 4, columns of B and C; must be a multiple of LANES
- LANES, 2, parallel lanes (column group width)
- DATA_WIDTH_INITIAL, 8, operand width
- ACC_WIDTH, 2*DATA_WIDTH_INITIAL+$clog2(param_K) (=18), accumulator and result width per lane

Ports:
- clk, input, 1, single clock; all logic on rising edge
- rst, input, 1, reset; synchronous, active-high
- mac_start, input, 1, start request; accepted only in IDLE
- signed_mode, input, 1, 1 = two's-complement operands; sampled with an accepted mac_start
- a_b_re, output, 1, read enable for A and B memories
- a_addr_out, output, max(1,$clog2(M*K)), A element address = m*K+k
- b_addr_out, output, max(1,$clog2(K*N/LANES)), B word address = k*(N/LANES)+g
- a_data_in, input, DATA_WIDTH_INITIAL, A element, valid the cycle after the read
- b_data_in, input, LANES*DATA_WIDTH_INITIAL, B word; lane j = column g*LANES+j at bits [j*DW +: DW]
- c_we, output, 1, C write enable
- c_addr_out, output, max(1,$clog2(M*N/LANES)), C word address = m*(N/LANES)+g
- c_data_out, output, LANES*ACC_WIDTH, lane j result at bits [j*ACC_WIDTH +: ACC_WIDTH]
- busy, output, 1, high from the cycle after an accepted start through the DONE cycle
- mac_done, output, 1, one-cycle completion pulse

Behaviour:
- Reset: synchronous and active-high. When rst is high at an edge:
  - all outputs go to 0; FSM goes to IDLE;
  - counters, pipeline valid bits and accumulators are cleared;
  - any in-flight operation is abandoned, with no further c_we or mac_done.
- FSM states:
  - IDLE -> RUN on mac_start.
  - RUN -> DRAIN after the last read is issued.
  - DRAIN lasts 3 cycles, then -> DONE.
  - DONE lasts 1 cycle (mac_done=1), then -> IDLE.
  - mac_start outside IDLE is ignored, including in the DONE cycle.
- Sequencing:
  - Loop order is m outer, g (0..N/LANES-1) middle, k inner.
  - One read per cycle, back to back, with a_b_re=1 for exactly T = M*(N/LANES)*K consecutive cycles, starting the cycle after the start edge.
  - Addresses are held at their last value when a_b_re=0.
- Pipeline, for a read issued in cycle c:
  - operands valid in cycle c+1;
  - products registered in cycle c+2;
  - accumulator updated and visible in cycle c+3.
  - A k==0 tag travels with the data and loads the accumulator with the product instead of adding to it.
- Write-back: when the k==K-1 entry reaches the accumulator, c_we=1 for one cycle in c+3, with c_addr_out/c_data_out taken from the registered accumulators. c_we is 0 at all other times. c_data_out holds its value between writes.
- Arithmetic:
  - signed_mode=1: operands are sign-extended and the product is a signed 2*DW value, sign-extended to ACC_WIDTH.
  - signed_mode=0: zero-extension throughout.
  - Accumulation wraps modulo 2^ACC_WIDTH. The default ACC_WIDTH cannot overflow.
- Completion: the final c_we is in cycle T+3 and mac_done pulses in T+4. busy drops to 0 in T+5.
- Back-to-back runs: a mac_start presented in T+5 (IDLE) starts a new run. Its first read occurs in T+6.
- Degenerate sizes: K=1 gives a c_we every cycle. LANES=N gives a single group per row.

Decomposition:
- Package mac_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - localparam functions for address widths and T;
  - DRAIN_CYCLES=3.
- Sub-module mac_lane holds one lane: the operand extension, product register, tag pipeline and accumulator. It is instantiated LANES times by a generate loop.
- The top level holds the FSM, the m/g/k counters, the address generation and the C-port registers.

Test Plan:
- Defaults, unsigned, A[i]=i, B[i]=i (i = flat index) -> 8 c_we pulses; first is c_addr=0 with lanes {62,56}, i.e. C[0][0]=56 and C[0][1]=62; last is c_addr=7 with lane1 = C[3][3] = 506. mac_done at cycle 36 after the start edge; a_b_re high for exactly 32 cycles.
- All A=0xFF, all B=0x02, signed_mode=1 -> every lane result = 0x3FFF8 (-8). Same run with signed_mode=0 -> every lane result = 0x007F8 (2040).
- rst asserted 10 cycles into a run -> next cycle all outputs 0, no c_we/mac_done thereafter. A fresh start then reproduces the scenario-1 results exactly.
- mac_start held high continuously -> run 2 begins only after IDLE: its first read is exactly 1 cycle after busy falls. Both runs produce identical C.
- LANES=4, M=2, K=1, N=4 -> a_b_re high 2 cycles; c_we in 2 consecutive cycles with c_addr 0 then 1; each result equals A[m]*B[n].
